// File: rtl/reg_write_sequencer.sv
// Write-back sequencer for the multicycle MIPS datapath: drives the register-write-address
// mux select, the register-bank write enable and the write-data select.
module reg_write_sequencer #(
    parameter int unsigned KIND_W = 3,
    parameter int unsigned SEL_W  = 3
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [KIND_W-1:0] wb_kind,
    input  logic              hold,
    output logic [1:0]        RegWriteMUX,
    output logic              RegWrite,
    output logic [SEL_W-1:0]  data_sel,
    output logic              busy,
    output logic              done,
    output logic              illegal
);

    localparam logic [KIND_W-1:0] K_NONE    = KIND_W'(0);
    localparam logic [KIND_W-1:0] K_RT      = KIND_W'(1);
    localparam logic [KIND_W-1:0] K_RD      = KIND_W'(2);
    localparam logic [KIND_W-1:0] K_LINK    = KIND_W'(3);
    localparam logic [KIND_W-1:0] K_PUSH    = KIND_W'(4);
    localparam logic [KIND_W-1:0] K_POP     = KIND_W'(5);
    localparam logic [KIND_W-1:0] K_LINK_RD = KIND_W'(6);
    localparam logic [KIND_W-1:0] K_RSVD    = KIND_W'(7);

    localparam logic [SEL_W-1:0] SEL_ALU = SEL_W'(0);
    localparam logic [SEL_W-1:0] SEL_MDR = SEL_W'(1);
    localparam logic [SEL_W-1:0] SEL_PC  = SEL_W'(2);
    localparam logic [SEL_W-1:0] SEL_SPM = SEL_W'(3);
    localparam logic [SEL_W-1:0] SEL_SPP = SEL_W'(4);

    localparam logic [1:0] MUX_RT = 2'b00;
    localparam logic [1:0] MUX_SP = 2'b01;
    localparam logic [1:0] MUX_RA = 2'b10;
    localparam logic [1:0] MUX_RD = 2'b11;

    typedef enum logic [1:0] {S_IDLE, S_WB1, S_WB2, S_DONE} state_t;

    state_t            r_state;
    state_t            w_next;
    logic [KIND_W-1:0] r_kind;
    logic [1:0]        r_mux;
    logic              r_rw;
    logic [SEL_W-1:0]  r_sel;
    logic              r_busy;
    logic              r_done;
    logic              r_ill;
    logic [1:0]        w_mux;
    logic              w_rw;
    logic [SEL_W-1:0]  w_sel;
    logic              w_busy;
    logic              w_done;
    logic              w_ill;

    // Outputs are registered from the current state, so they trail the state by one edge;
    // this lets hold gate the write on the same cycle the write step is visible.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_kind  <= '0;
            r_mux   <= MUX_RT;
            r_rw    <= 1'b0;
            r_sel   <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_ill   <= 1'b0;
        end else begin
            r_state <= w_next;
            if (r_state == S_IDLE && start)
                r_kind <= wb_kind;
            r_mux   <= w_mux;
            r_rw    <= w_rw;
            r_sel   <= w_sel;
            r_busy  <= w_busy;
            r_done  <= w_done;
            r_ill   <= w_ill;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    if (wb_kind == K_NONE || wb_kind == K_RSVD)
                        w_next = S_DONE;
                    else
                        w_next = S_WB1;
                end
            end
            S_WB1: begin
                if (!hold)
                    w_next = (r_kind == K_POP) ? S_WB2 : S_DONE;
            end
            S_WB2: begin
                if (!hold)
                    w_next = S_DONE;
            end
            S_DONE:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_comb begin
        w_mux  = r_mux;
        w_sel  = r_sel;
        w_rw   = 1'b0;
        w_done = 1'b0;
        w_ill  = 1'b0;
        w_busy = (r_state != S_IDLE);
        case (r_state)
            S_WB1: begin
                w_rw = ~hold;
                case (r_kind)
                    K_RT:      begin w_mux = MUX_RT; w_sel = SEL_ALU; end
                    K_RD:      begin w_mux = MUX_RD; w_sel = SEL_ALU; end
                    K_LINK:    begin w_mux = MUX_RA; w_sel = SEL_PC;  end
                    K_PUSH:    begin w_mux = MUX_SP; w_sel = SEL_SPM; end
                    K_POP:     begin w_mux = MUX_RT; w_sel = SEL_MDR; end
                    K_LINK_RD: begin w_mux = MUX_RD; w_sel = SEL_PC;  end
                    default:   w_rw = 1'b0;
                endcase
            end
            S_WB2: begin
                w_rw  = ~hold;
                w_mux = MUX_SP;
                w_sel = SEL_SPP;
            end
            S_DONE: begin
                w_done = 1'b1;
                w_ill  = (r_kind == K_RSVD);
            end
            default: ;
        endcase
    end

    assign RegWriteMUX = r_mux;
    assign RegWrite    = r_rw;
    assign data_sel    = r_sel;
    assign busy        = r_busy;
    assign done        = r_done;
    assign illegal     = r_ill;

endmodule

// File: tb/tb_reg_write_sequencer.sv
// Directed bench for reg_write_sequencer: one table row per clock edge, plus sequences
// for reset during POP and POP with hold in both write steps.
module tb_reg_write_sequencer;

    logic       clk = 1'b0;
    logic       reset, start, hold;
    logic [2:0] wb_kind;
    logic [1:0] RegWriteMUX;
    logic       RegWrite;
    logic [2:0] data_sel;
    logic       busy, done, illegal;

    always #5 clk = ~clk;

    reg_write_sequencer #(.KIND_W(3), .SEL_W(3)) dut (
        .clk(clk), .reset(reset), .start(start), .wb_kind(wb_kind), .hold(hold),
        .RegWriteMUX(RegWriteMUX), .RegWrite(RegWrite), .data_sel(data_sel),
        .busy(busy), .done(done), .illegal(illegal)
    );

    typedef struct {
        string      name;
        logic       rst;
        logic       st;
        logic [2:0] kind;
        logic       hold;
        logic [8:0] exp;  // {mux[1:0], rw, sel[2:0], busy, done, ill}
    } vec_t;

    vec_t vecs[$];
    int   n_pass = 0;
    int   n_total = 0;

    function automatic void add(input string nm, input logic rst, input logic st,
                                input logic [2:0] kind, input logic hold,
                                input logic [1:0] mux, input logic rw, input logic [2:0] sel,
                                input logic bsy, input logic dn, input logic ill);
        vec_t v;
        v.name = nm; v.rst = rst; v.st = st; v.kind = kind; v.hold = hold;
        v.exp  = {mux, rw, sel, bsy, dn, ill};
        vecs.push_back(v);
    endfunction

    function automatic logic [8:0] outs();
        return {RegWriteMUX, RegWrite, data_sel, busy, done, illegal};
    endfunction

    task automatic check9(input string nm, input logic [8:0] got, input logic [8:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: {mux,rw,sel,busy,done,ill} actual=%b required=%b", nm, got, exp);
    endtask

    task automatic check_int(input string nm, input int got, input int exp);
        n_total++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: actual=%0d required=%0d", nm, got, exp);
    endtask

    task automatic step(input logic rst, input logic st, input logic [2:0] kind, input logic hd);
        @(negedge clk);
        reset = rst; start = st; wb_kind = kind; hold = hd;
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int pulses, dones, seen_done;
        logic [1:0] p_mux [2];
        logic [2:0] p_sel [2];

        reset = 1'b1; start = 1'b0; wb_kind = 3'd0; hold = 1'b0;

        //   name          rst st kind hold  mux   rw sel   bsy dn ill
        add("reset0",      1, 0, 3'd0, 0, 2'b00, 0, 3'd0, 0, 0, 0);
        add("reset1",      1, 0, 3'd0, 0, 2'b00, 0, 3'd0, 0, 0, 0);
        add("rd_start",    0, 1, 3'd2, 0, 2'b00, 0, 3'd0, 0, 0, 0);
        add("rd_write",    0, 0, 3'd0, 0, 2'b11, 1, 3'd0, 1, 0, 0);
        add("rd_done",     0, 0, 3'd0, 0, 2'b11, 0, 3'd0, 1, 1, 0);
        add("rd_idle",     0, 0, 3'd0, 0, 2'b11, 0, 3'd0, 0, 0, 0);
        add("pop_start",   0, 1, 3'd5, 0, 2'b11, 0, 3'd0, 0, 0, 0);
        add("pop_wr_rt",   0, 0, 3'd0, 0, 2'b00, 1, 3'd1, 1, 0, 0);
        add("pop_wr_sp",   0, 0, 3'd0, 0, 2'b01, 1, 3'd4, 1, 0, 0);
        add("pop_done",    0, 0, 3'd0, 0, 2'b01, 0, 3'd4, 1, 1, 0);
        add("pop_idle",    0, 0, 3'd0, 0, 2'b01, 0, 3'd4, 0, 0, 0);
        add("push_start",  0, 1, 3'd4, 0, 2'b01, 0, 3'd4, 0, 0, 0);
        add("push_hold1",  0, 0, 3'd2, 1, 2'b01, 0, 3'd3, 1, 0, 0);
        add("push_hold2",  0, 0, 3'd2, 1, 2'b01, 0, 3'd3, 1, 0, 0);
        add("push_hold3",  0, 0, 3'd2, 1, 2'b01, 0, 3'd3, 1, 0, 0);
        add("push_write",  0, 0, 3'd2, 0, 2'b01, 1, 3'd3, 1, 0, 0);
        add("push_done",   0, 0, 3'd2, 0, 2'b01, 0, 3'd3, 1, 1, 0);
        add("push_idle",   0, 0, 3'd0, 0, 2'b01, 0, 3'd3, 0, 0, 0);
        add("link_start",  0, 1, 3'd3, 0, 2'b01, 0, 3'd3, 0, 0, 0);
        add("link_wr_ign", 0, 1, 3'd5, 0, 2'b10, 1, 3'd2, 1, 0, 0);
        add("link_dn_ign", 0, 1, 3'd5, 0, 2'b10, 0, 3'd2, 1, 1, 0);
        add("link_idle",   0, 0, 3'd0, 0, 2'b10, 0, 3'd2, 0, 0, 0);
        add("link_no_2nd", 0, 0, 3'd0, 0, 2'b10, 0, 3'd2, 0, 0, 0);
        add("rsvd_start",  0, 1, 3'd7, 0, 2'b10, 0, 3'd2, 0, 0, 0);
        add("rsvd_done",   0, 0, 3'd0, 0, 2'b10, 0, 3'd2, 1, 1, 1);
        add("rsvd_idle",   0, 0, 3'd0, 0, 2'b10, 0, 3'd2, 0, 0, 0);
        add("none_start",  0, 1, 3'd0, 0, 2'b10, 0, 3'd2, 0, 0, 0);
        add("none_done",   0, 0, 3'd0, 0, 2'b10, 0, 3'd2, 1, 1, 0);
        add("none_idle",   0, 0, 3'd0, 0, 2'b10, 0, 3'd2, 0, 0, 0);
        add("rt_start",    0, 1, 3'd1, 0, 2'b10, 0, 3'd2, 0, 0, 0);
        add("rt_write",    0, 0, 3'd0, 0, 2'b00, 1, 3'd0, 1, 0, 0);
        add("rt_done",     0, 0, 3'd0, 0, 2'b00, 0, 3'd0, 1, 1, 0);
        add("rt_idle",     0, 0, 3'd0, 0, 2'b00, 0, 3'd0, 0, 0, 0);
        add("lrd_start",   0, 1, 3'd6, 0, 2'b00, 0, 3'd0, 0, 0, 0);
        add("lrd_write",   0, 0, 3'd0, 0, 2'b11, 1, 3'd2, 1, 0, 0);
        add("lrd_done",    0, 0, 3'd0, 0, 2'b11, 0, 3'd2, 1, 1, 0);
        add("lrd_idle",    0, 0, 3'd0, 0, 2'b11, 0, 3'd2, 0, 0, 0);
        add("idle_hold",   0, 1, 3'd1, 1, 2'b11, 0, 3'd2, 0, 0, 0);
        add("ih_write",    0, 0, 3'd0, 0, 2'b00, 1, 3'd0, 1, 0, 0);
        add("ih_done_hld", 0, 0, 3'd0, 1, 2'b00, 0, 3'd0, 1, 1, 0);
        add("ih_idle",     0, 0, 3'd0, 0, 2'b00, 0, 3'd0, 0, 0, 0);

        foreach (vecs[i]) begin
            step(vecs[i].rst, vecs[i].st, vecs[i].kind, vecs[i].hold);
            check9(vecs[i].name, outs(), vecs[i].exp);
        end

        // Reset held two cycles while POP sits in WB1: no write at all, back to IDLE.
        step(0, 1, 3'd5, 0);
        step(1, 0, 3'd0, 0);
        check9("rst_pop_a", outs(), 9'b00_0_000_0_0_0);
        step(1, 0, 3'd0, 0);
        check9("rst_pop_b", outs(), 9'b00_0_000_0_0_0);
        pulses = 0; dones = 0;
        for (int c = 0; c < 6; c++) begin
            step(0, 0, 3'd0, 0);
            if (RegWrite) pulses++;
            if (done) dones++;
        end
        check_int("rst_pop_no_write", pulses, 0);
        check_int("rst_pop_no_done", dones, 0);
        check9("rst_pop_idle", outs(), 9'b00_0_000_0_0_0);

        // POP with hold stalling both write steps: exactly two pulses, in order.
        step(0, 1, 3'd5, 0);
        pulses = 0; dones = 0; seen_done = 0;
        p_mux[0] = 2'bxx; p_mux[1] = 2'bxx; p_sel[0] = 3'bxxx; p_sel[1] = 3'bxxx;
        for (int c = 0; c < 40 && seen_done == 0; c++) begin
            step(0, 1, 3'd1, (c % 3) != 2);
            if (RegWrite) begin
                if (pulses < 2) begin
                    p_mux[pulses] = RegWriteMUX;
                    p_sel[pulses] = data_sel;
                end
                pulses++;
            end
            if (done) begin
                dones++;
                seen_done = 1;
            end
        end
        check_int("pop_hold_done_seen", seen_done, 1);
        check_int("pop_hold_pulses", pulses, 2);
        check_int("pop_hold_mux1", int'(p_mux[0]), 0);
        check_int("pop_hold_sel1", int'(p_sel[0]), 1);
        check_int("pop_hold_mux2", int'(p_mux[1]), 1);
        check_int("pop_hold_sel2", int'(p_sel[1]), 4);
        step(0, 0, 3'd0, 0);
        check9("pop_hold_idle", outs(), 9'b01_0_100_0_0_0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
